// File: rtl/bcd_conv_arbiter_if.sv
// Request/result bundle between the requesters, the converter and the consumer.
interface bcd_conv_arbiter_if #(parameter int unsigned NREQ = 4);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [11:0]       out_bcd;
  logic [1:0]        out_id;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_bcd, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_bcd, out_id
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter feeding a serial double-dabble binary-to-BCD converter.
// One operand is converted at a time; the result is held until the consumer takes it.
module bcd_conv_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_conv_arbiter_if.slave  bus,
  output logic               busy_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_OUTPUT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [1:0]      last_q;
  logic [2:0]      cnt_q;
  logic [7:0]      sh_q;
  logic [3:0]      hun_q, ten_q, uni_q;
  logic [11:0]     bcd_q;
  logic [1:0]      id_q;

  logic [NREQ-1:0] grant;
  logic [1:0]      gidx;
  logic [7:0]      sel_data;
  logic            found;
  logic            accept;
  int unsigned     start;
  logic [3:0]      hun_adj, ten_adj, uni_adj;
  logic [19:0]     shifted;

  // Search begins one past the last winner and wraps, so the first hit is the grant.
  always_comb begin
    grant    = '0;
    gidx     = '0;
    sel_data = '0;
    found    = 1'b0;
    start    = 32'(last_q) + 32'd1;
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && (i == ((start + off) % NREQ)) && bus.req_valid[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gidx     = 2'(i);
          sel_data = bus.req_data[8*i +: 8];
        end
      end
    end
  end

  assign accept = (state_q == S_IDLE) && found;

  always_comb begin
    hun_adj = (hun_q > 4'd4) ? hun_q + 4'd3 : hun_q;
    ten_adj = (ten_q > 4'd4) ? ten_q + 4'd3 : ten_q;
    uni_adj = (uni_q > 4'd4) ? uni_q + 4'd3 : uni_q;
    shifted = {hun_adj, ten_adj, uni_adj, sh_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_CONVERT;
      S_CONVERT: if (cnt_q == 3'd7) state_d = S_OUTPUT;
      S_OUTPUT:  if (bus.out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 2'(NREQ - 1);
      cnt_q   <= '0;
      sh_q    <= '0;
      hun_q   <= '0;
      ten_q   <= '0;
      uni_q   <= '0;
      bcd_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sh_q   <= sel_data;
            id_q   <= gidx;
            last_q <= gidx;
            hun_q  <= '0;
            ten_q  <= '0;
            uni_q  <= '0;
            cnt_q  <= '0;
          end
        end
        S_CONVERT: begin
          {hun_q, ten_q, uni_q, sh_q} <= shifted;
          cnt_q <= cnt_q + 3'd1;
          // Published result lives apart from the working digits so it holds outside OUTPUT.
          if (cnt_q == 3'd7) bcd_q <= shifted[19:8];
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (rst_n && (state_q == S_IDLE)) ? grant : '0;
  assign bus.out_valid = (state_q == S_OUTPUT);
  assign bus.out_bcd   = bcd_q;
  assign bus.out_id    = id_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: an acceptance monitor predicts grant and
// BCD result, and the output monitor pops and compares on each handshake.
module tb_bcd_conv_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  int   acc_cyc = 0;
  int   model_last = N - 1;
  bit   have_prev_acc = 1'b0;
  logic        prev_ov = 1'b0;
  logic        prev_ordy = 1'b0;
  logic [11:0] prev_bcd = '0;
  logic [1:0]  prev_id = '0;

  logic [13:0] sb[$];
  int          grants_q[$];
  int          spacing_q[$];

  bcd_conv_arbiter_if #(.NREQ(N)) bus ();

  bcd_conv_arbiter #(.NREQ(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int       g;
    logic [13:0] e;
    if (!rst_n) begin
      prev_ov       = 1'b0;
      model_last    = N - 1;
      have_prev_acc = 1'b0;
    end else begin
      if (!busy) begin
        g = rr_pick(model_last, bus.req_valid);
        check_eq("req_ready_idle", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check_eq("out_valid_idle", 32'(bus.out_valid), 32'd0);
        if (g >= 0) begin
          sb.push_back({2'(g), to_bcd(int'(bus.req_data[8*g +: 8]))});
          grants_q.push_back(g);
          if (have_prev_acc) spacing_q.push_back(cyc - acc_cyc);
          have_prev_acc = 1'b1;
          acc_cyc       = cyc;
          model_last    = g;
          acc_cnt++;
        end
      end else begin
        check_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
        if (bus.out_valid) begin
          if (!prev_ov) check_eq("latency", 32'(cyc - acc_cyc), 32'd9);
          else if (!prev_ordy) begin
            check_eq("hold_bcd", 32'(bus.out_bcd), 32'(prev_bcd));
            check_eq("hold_id", 32'(bus.out_id), 32'(prev_id));
          end
          if (bus.out_ready) begin
            if (sb.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
            else begin
              e = sb.pop_front();
              check_eq("out_bcd", 32'(bus.out_bcd), 32'(e[11:0]));
              check_eq("out_id", 32'(bus.out_id), 32'(e[13:12]));
            end
            out_cnt++;
          end
        end
      end
      prev_ov   = bus.out_valid;
      prev_ordy = bus.out_ready;
      prev_bcd  = bus.out_bcd;
      prev_id   = bus.out_id;
    end
  end

  task automatic wait_acc(input int n0);
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (acc_cnt != n0) begin ok = 1'b1; break; end
    end
    check_eq("acc_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_out(input int n0);
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (out_cnt != n0) begin ok = 1'b1; break; end
    end
    check_eq("out_wait", 32'(ok), 32'd1);
  endtask

  task automatic do_reset(input logic [N-1:0] vmask);
    bus.req_valid = vmask;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_bcd", 32'(bus.out_bcd), 32'd0);
    check_eq("rst_out_id", 32'(bus.out_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    sb.delete();
    grants_q.delete();
    spacing_q.delete();
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drop the request right after acceptance and scramble its data to prove it was latched.
  task automatic do_req(input int id, input logic [7:0] d);
    int a0, o0;
    a0 = acc_cnt;
    o0 = out_cnt;
    bus.req_data[8*id +: 8] = d;
    bus.req_valid[id] = 1'b1;
    wait_acc(a0);
    bus.req_valid[id] = 1'b0;
    bus.req_data[8*id +: 8] = 8'($urandom);
    wait_out(o0);
  endtask

  initial begin
    int n0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    #1;
    do_reset(4'b0001);

    do_req(0, 8'hFF);
    do_req(0, 8'h00);
    do_req(0, 8'h63);
    for (int v = 0; v < 256; v++) do_req(v % N, 8'(v));

    // All four requesters pending from reset.
    do_reset(4'b1111);
    bus.req_data = {8'd40, 8'd30, 8'd20, 8'd10};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_acc(acc_cnt);
      bus.req_valid[grants_q[grants_q.size()-1]] = 1'b0;
    end
    n0 = out_cnt;
    for (int k = 0; k < 60 && out_cnt < n0 + 1; k++) begin @(posedge clk); #1; end
    for (int k = 0; k < 60 && busy; k++) begin @(posedge clk); #1; end
    check_eq("rr4_count", 32'(grants_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < grants_q.size(); k++) check_eq("rr4_order", 32'(grants_q[k]), 32'(k));
    check_eq("rr4_spacing_n", 32'(spacing_q.size()), 32'd3);
    foreach (spacing_q[k]) check_eq("rr4_spacing", 32'(spacing_q[k]), 32'd10);
    check_eq("rr4_sb_drained", 32'(sb.size()), 32'd0);

    // Consumer stalls for five cycles while another request waits.
    bus.out_ready = 1'b0;
    bus.req_data[7:0] = 8'd137;
    bus.req_valid[0] = 1'b1;
    wait_acc(acc_cnt);
    bus.req_valid[0] = 1'b0;
    bus.req_data[15:8] = 8'd5;
    bus.req_valid[1] = 1'b1;
    for (int k = 0; k < 20 && !bus.out_valid; k++) begin @(posedge clk); #1; end
    for (int k = 0; k < 5; k++) begin
      check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
      check_eq("stall_bcd", 32'(bus.out_bcd), 32'h137);
      check_eq("stall_id", 32'(bus.out_id), 32'd0);
      check_eq("stall_ready", 32'(bus.req_ready), 32'd0);
      check_eq("stall_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    n0 = acc_cnt;
    bus.out_ready = 1'b1;
    wait_acc(n0);
    bus.req_valid[1] = 1'b0;
    for (int k = 0; k < 60 && (busy || sb.size() != 0); k++) begin @(posedge clk); #1; end
    check_eq("stall_drained", 32'(sb.size()), 32'd0);

    // Reset during CONVERT cycle 4 aborts the operation.
    do_reset('0);
    n0 = acc_cnt;
    bus.req_data[23:16] = 8'hC8;
    bus.req_valid[2] = 1'b1;
    wait_acc(n0);
    bus.req_valid[2] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("abort_busy_pre", 32'(busy), 32'd1);
    n0 = out_cnt;
    do_reset(4'b0010);
    repeat (20) begin @(posedge clk); #1; end
    check_eq("abort_no_out", 32'(out_cnt), 32'(n0));
    do_req(1, 8'hC8);

    // Wrap order: grant 2, then 1 and 3 pending -> 3 before 1.
    do_reset('0);
    do_req(2, 8'd77);
    bus.req_data[15:8]  = 8'd11;
    bus.req_data[31:24] = 8'd33;
    bus.req_valid = 4'b1010;
    wait_acc(acc_cnt);
    check_eq("wrap_first", 32'(grants_q[grants_q.size()-1]), 32'd3);
    bus.req_valid[3] = 1'b0;
    wait_acc(acc_cnt);
    check_eq("wrap_second", 32'(grants_q[grants_q.size()-1]), 32'd1);
    bus.req_valid[1] = 1'b0;
    for (int k = 0; k < 60 && (busy || sb.size() != 0); k++) begin @(posedge clk); #1; end
    check_eq("final_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal range 2..4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous active-low.
REQ-004 req_valid  input  NREQ  per-requester request strobe.
REQ-005 req_data  input  8*NREQ  binary operands; requester i on bits [8i+7:8i].
REQ-006 req_ready  output  NREQ  one-hot acceptance indication.
REQ-007 out_valid  output  1  result available.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 out_bcd  output  12  result {hundreds, tens, units}, 4 bits per digit.
REQ-010 out_id  output  2  index of the requester that owns out_bcd.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CONVERT, OUTPUT.
REQ-013 In IDLE, req_ready SHALL combinationally equal the one-hot round-robin grant over req_valid; all zero if no req_valid bit is set.
REQ-014 Round-robin: search starts at (last_grant+1) mod NREQ and proceeds upward with wrap; last_grant updates only on acceptance.
REQ-015 Acceptance = IDLE and req_valid[g] and req_ready[g]; at that edge the block latches req_data[g] into the shift register, g into out_id, clears digits and the bit counter, and goes to CONVERT.
REQ-016 req_ready SHALL be all zero in CONVERT and OUTPUT; requests there are held, not dropped (requester keeps req_valid high).
REQ-017 CONVERT processes one bit per cycle, MSB first, for exactly 8 cycles: each digit >4 gets +3 (4-bit, no carry out), then {hundreds,tens,units,operand} shifts left by one.
REQ-018 After the 8th CONVERT cycle, the FSM enters OUTPUT with out_valid=1; the first out_valid cycle is 9 cycles after the acceptance edge.
REQ-019 In OUTPUT, out_bcd and out_id SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 On out_valid and out_ready, the FSM returns to IDLE; no new acceptance in that same cycle; minimum spacing between acceptances is 10 cycles.
REQ-021 out_valid SHALL be 0 outside OUTPUT; out_bcd/out_id retain their last values outside OUTPUT.
REQ-022 Arithmetic: for any operand 0..255, out_bcd SHALL equal its exact 3-digit decimal value; the hundreds digit never exceeds 2.
REQ-023 req_data changes after acceptance SHALL NOT affect the result.

Reset
REQ-024 On rst_n low, immediately: state=IDLE, out_valid=0, out_bcd=0, out_id=0, busy=0, counter=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-025 Reset asserted mid-CONVERT or mid-OUTPUT aborts the operation; no out_valid is produced for it after release.
REQ-026 req_ready SHALL be 0 while rst_n is low.

Verification
REQ-027 Single req 0 with data 8'hFF, out_ready=1 -> out_valid 9 cycles after acceptance, out_bcd=12'h255, out_id=0.
REQ-028 Data 8'h00 and 8'h63 -> out_bcd=12'h000 and 12'h099 respectively; exhaustive 0..255 sweep matches reference decimal.
REQ-029 All four req_valid high from reset, data 10/20/30/40 -> grants in order 0,1,2,3, results 12'h010,12'h020,12'h030,12'h040, acceptances 10 cycles apart.
REQ-030 out_ready held low 5 cycles in OUTPUT -> out_valid, out_bcd, out_id unchanged, req_ready all zero, busy=1 throughout.
REQ-031 rst_n pulsed low at CONVERT cycle 4 of data 8'hC8 -> outputs reset immediately, no out_valid; a new request after release yields the correct result.
REQ-032 Grant to 2, then only req 1 and 3 valid -> next grant is 3 (wrap-order check).
